// File: rtl/div_pkg.sv
// Shared divider definitions: state encoding, width defaults and the
// UDIV/SDIV control encoding used by both the decoder and the divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [DIV_WIDTH-1:0] DIV_MOST_NEG =
    {1'b1, {(DIV_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  typedef enum logic {
    OP_UDIV = 1'b0,
    OP_SDIV = 1'b1
  } div_op_t;

endpackage

// File: rtl/div_unit_step.sv
// Single radix-2 restoring division step, purely combinational.
// The trial subtract is one bit wider than the operands to keep the borrow.
import div_pkg::*;

module div_unit_step #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted  = {rem, bit_in};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = ~diff[WIDTH];
  // Either choice is below the divisor, so the top bit is always zero.
  assign rem_next = q_bit ? diff[WIDTH-1:0]
                          : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative UDIV/SDIV unit: one quotient bit per cycle with a
// start/busy/done handshake for the execute-stage stall logic.
import div_pkg::*;

module div_unit #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivZero,
  output logic             Overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  div_state_t state;
  div_state_t state_next;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic             q_neg;
  logic             r_neg;
  logic             ovf_pend;

  logic             sgn;
  logic             accept;
  logic             b_zero;
  logic             last;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] prem_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_mag;

  assign sgn    = (Signed == OP_SDIV);
  assign b_zero = (SrcB == '0);
  assign accept = Start && (state != CALC);
  assign last   = (count == LAST);
  assign Busy   = (state == CALC);
  assign Done   = (state == DONE);

  always_comb begin
    a_mag = SrcA;
    b_mag = SrcB;
    if (sgn && SrcA[WIDTH-1]) a_mag = ~SrcA + 1'b1;
    if (sgn && SrcB[WIDTH-1]) b_mag = ~SrcB + 1'b1;
  end

  div_unit_step #(.WIDTH(WIDTH)) u_step (
    .rem      (prem),
    .divisor  (dvs),
    .bit_in   (dvd[WIDTH-1]),
    .rem_next (prem_next),
    .q_bit    (q_bit)
  );

  assign q_mag = {dvd[WIDTH-2:0], q_bit};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: begin
        if (!Start)      state_next = IDLE;
        else if (b_zero) state_next = DONE;
        else             state_next = CALC;
      end
      CALC: if (last) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      dvd       <= '0;
      dvs       <= '0;
      prem      <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      ovf_pend  <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      DivZero   <= 1'b0;
      Overflow  <= 1'b0;
    end else if (accept) begin
      count    <= '0;
      dvd      <= a_mag;
      dvs      <= b_mag;
      prem     <= '0;
      q_neg    <= sgn && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
      r_neg    <= sgn && SrcA[WIDTH-1];
      ovf_pend <= sgn && (SrcA == MOST_NEG) && (&SrcB);
      // Divide by zero skips the datapath and finishes in one cycle.
      if (b_zero) begin
        Quotient  <= '0;
        Remainder <= SrcA;
        DivZero   <= 1'b1;
        Overflow  <= 1'b0;
      end
    end else if (state == CALC) begin
      count <= count + 1'b1;
      dvd   <= q_mag;
      prem  <= prem_next;
      if (last) begin
        Quotient  <= q_neg ? (~q_mag + 1'b1) : q_mag;
        Remainder <= r_neg ? (~prem_next + 1'b1)
                           : prem_next;
        DivZero   <= 1'b0;
        Overflow  <= ovf_pend;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results are queued on issue
// and compared when Done is observed.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Start = 1'b0;
  logic        Signed = 1'b0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        Busy;
  logic        Done;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        DivZero;
  logic        Overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
  } exp_t;

  exp_t sb[$];

  div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .Signed    (Signed),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Busy      (Busy),
    .Done      (Done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivZero   (DivZero),
    .Overflow  (Overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic s);
    exp_t m;
    m.dz = 1'b0;
    m.ov = 1'b0;
    if (b == 32'h0) begin
      m.q = 32'h0;
      m.r = a;
      m.dz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      m.q = 32'h8000_0000;
      m.r = 32'h0;
      m.ov = 1'b1;
    end else if (s) begin
      m.q = $signed(a) / $signed(b);
      m.r = $signed(a) % $signed(b);
    end else begin
      m.q = a / b;
      m.r = a % b;
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic s, input bit hold);
    SrcA = a;
    SrcB = b;
    Signed = s;
    Start = 1'b1;
    sb.push_back(model(a, b, s));
    tick();
    if (!hold) Start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_n,
                           output bit ok);
    lat = 0;
    busy_n = 0;
    ok = 1'b1;
    while (Done !== 1'b1) begin
      if (lat >= 200) begin
        ok = 1'b0;
        break;
      end
      if (Busy === 1'b1) busy_n++;
      tick();
      lat++;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_timeout: waited %0d cycles, required Done", lat);
    end else if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_with_done: Busy=%b, required 0", Busy);
    end
  endtask

  task automatic check_result(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    if ({Quotient, Remainder, DivZero, Overflow} !==
        {e.q, e.r, e.dz, e.ov}) begin
      errors++;
      $display("FAIL %s: got q=%h r=%h dz=%b ov=%b, required q=%h r=%h dz=%b ov=%b",
               name, Quotient, Remainder, DivZero, Overflow,
               e.q, e.r, e.dz, e.ov);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({Busy, Done, DivZero, Overflow, Quotient, Remainder} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dz=%b ov=%b, required all 0",
               Busy, Done, Quotient, Remainder, DivZero, Overflow);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_unsigned();
    int lat, bn;
    bit ok;
    logic [31:0] ta [5] = '{32'd5, 32'd12345, 32'hFFFF_FFFF,
                            32'd77, 32'hDEAD_BEEF};
    logic [31:0] tb [5] = '{32'd9, 32'd1, 32'hFFFF_FFFF,
                            32'd77, 32'h0000_0100};
    issue(32'd100, 32'd7, 1'b0, 1'b0);
    wait_done(lat, bn, ok);
    checks++;
    if (lat !== 32 || bn !== 32) begin
      errors++;
      $display("FAIL udiv_latency: lat=%0d busy=%0d, required 32/32",
               lat, bn);
    end
    check_result("udiv_100_7");
    tick();
    checks++;
    if (Done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: Done=%b, required 0", Done);
    end
    for (int i = 0; i < 5; i++) begin
      issue(ta[i], tb[i], 1'b0, 1'b0);
      wait_done(lat, bn, ok);
      check_result("udiv_table");
    end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      if (b == 0) b = 32'd3;
      issue(a, b, 1'b0, 1'b0);
      wait_done(lat, bn, ok);
      check_result("udiv_random");
    end
  endtask

  task automatic test_signed();
    int lat, bn;
    bit ok;
    issue(32'hFFFF_FFF9, 32'h2, 1'b1, 1'b0);
    wait_done(lat, bn, ok);
    check_result("sdiv_m7_2");
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
    wait_done(lat, bn, ok);
    check_result("sdiv_7_m2");
    issue(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 1'b0);
    wait_done(lat, bn, ok);
    check_result("sdiv_m7_m2");
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 30);
      if (b == 0) b = 32'hFFFF_FFFB;
      if ($urandom_range(0, 1) == 1) b = ~b + 1;
      issue(a, b, 1'b1, 1'b0);
      wait_done(lat, bn, ok);
      check_result("sdiv_random");
    end
  endtask

  task automatic test_divzero();
    int lat, bn;
    bit ok;
    issue(32'h1234_5678, 32'h0, 1'b0, 1'b0);
    wait_done(lat, bn, ok);
    checks++;
    if (lat !== 0 || bn !== 0) begin
      errors++;
      $display("FAIL divzero_latency: lat=%0d busy=%0d, required 0/0",
               lat, bn);
    end
    check_result("divzero");
    tick();
    issue(32'h8765_4321, 32'h0, 1'b1, 1'b0);
    wait_done(lat, bn, ok);
    check_result("divzero_signed");
  endtask

  task automatic test_overflow();
    int lat, bn;
    bit ok;
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_done(lat, bn, ok);
    check_result("sdiv_overflow");
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_done(lat, bn, ok);
    check_result("udiv_no_overflow");
  endtask

  task automatic test_start_ignored();
    int lat, bn;
    bit ok;
    issue(32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (5) tick();
    SrcA = 32'd77;
    SrcB = 32'd5;
    Signed = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_done(lat, bn, ok);
    checks++;
    if (lat !== 26) begin
      errors++;
      $display("FAIL ignore_latency: lat=%0d, required 26", lat);
    end
    check_result("start_ignored");
  endtask

  task automatic test_back_to_back();
    int lat, bn;
    bit ok;
    issue(32'd5000, 32'd13, 1'b0, 1'b1);
    SrcA = 32'hFFFF_FF00;
    SrcB = 32'd10;
    Signed = 1'b1;
    sb.push_back(model(SrcA, SrcB, Signed));
    wait_done(lat, bn, ok);
    check_result("b2b_first");
    tick();
    Start = 1'b0;
    checks++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_bubble: busy=%b done=%b, required 1/0",
               Busy, Done);
    end
    wait_done(lat, bn, ok);
    checks++;
    if (lat + 1 !== 33) begin
      errors++;
      $display("FAIL b2b_spacing: %0d cycles, required 33", lat + 1);
    end
    check_result("b2b_second");
  endtask

  task automatic test_reset_mid_calc();
    int lat, bn;
    bit ok;
    exp_t drop;
    bit saw_done;
    issue(32'hCAFE_F00D, 32'd9, 1'b0, 1'b0);
    repeat (10) tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({Busy, Done, DivZero, Overflow, Quotient, Remainder} !== '0) begin
      errors++;
      $display("FAIL reset_abort: got busy=%b done=%b q=%h r=%h dz=%b ov=%b, required all 0",
               Busy, Done, Quotient, Remainder, DivZero, Overflow);
    end
    drop = sb.pop_front();
    saw_done = 1'b0;
    repeat (40) begin
      tick();
      if (Done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL reset_no_done: Done=1 seen, required 0 (q=%h)",
               drop.q);
    end
    reset = 1'b1;
    tick();
    issue(32'd999, 32'd10, 1'b0, 1'b0);
    wait_done(lat, bn, ok);
    check_result("after_reset");
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_divzero();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_calc();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
